i2c_poll_scheduler: RTL and testbench
=====================================

Name: i2c_poll_scheduler

Overview:
- Time-shares one `i2c_controller_read` engine among up to NUM_DEV slave devices.
- Round-robin polls each enabled device address, issues the engine start, and waits for the transfer to finish.
- Captures the returned byte per device and retries on NACK or timeout.
- Sits between the engine and the Wishbone register file of the wb_i2c block.

Parameters:
- NUM_DEV, 4, number of polled devices (1..8).
- GAP_CYC, 16'd5000, idle clk cycles between consecutive transactions.
- TMO_CYC, 24'd2000000, clk cycles allowed per transaction phase before abort.
- MAX_RETRY, 2, extra attempts after a failed transaction (0..7).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- poll_en  in  1  global enable; 0 = finish current transaction, then stay in IDLE.
- dev_mask  in  NUM_DEV  per-device enable.
- dev_addr  in  7*NUM_DEV  7-bit slave address, device i at [7i+6:7i].
- eng_start  out  1  start pulse to engine.
- eng_addr  out  7  address/command byte to engine `i2c_data`.
- eng_done  in  1  engine `done` (level, high while engine idle at last stage).
- eng_ack  in  1  engine `ack` (1 = both ACKs received).
- eng_rdata  in  8  engine `i2c_data_out`.
- rd_data  out  8*NUM_DEV  last good byte per device.
- rd_upd  out  NUM_DEV  one-cycle pulse when rd_data[i] is written.
- dev_fail  out  NUM_DEV  sticky failure flag; cleared by the next good read of that device.
- cur_dev  out  3  index being serviced.
- busy  out  1  high outside IDLE/GAP.

Behaviour:
- Reset values: eng_start=0, eng_addr=0, rd_data=0, rd_upd=0, dev_fail=0, cur_dev=0, busy=0; state=IDLE, retry counter and timer = 0.
- IDLE → PICK when poll_en=1 and (dev_mask≠0).
- PICK (1 cycle):
  - Round-robin search starting at cur_dev+1 (wrap NUM_DEV-1→0) for the first masked-in device; if only cur_dev is enabled, reselect it.
  - Latch eng_addr = dev_addr[cur_dev]. → ISSUE.
- ISSUE: hold eng_start=1 until eng_done falls (the engine samples start on its slow mclk domain; pulse must span ≥1 mclk period). Timer runs; if TMO_CYC elapses → FAIL. On eng_done=0 → deassert eng_start, → WAIT.
- WAIT: wait for eng_done=1. Timeout → FAIL. On eng_done=1 → CHECK.
- CHECK (1 cycle):
  - eng_ack=1: rd_data[cur_dev] ← eng_rdata, rd_upd[cur_dev]=1 for this cycle, dev_fail[cur_dev] ← 0, retry ← 0. → GAP.
  - eng_ack=0 → FAIL.
- FAIL: if retry<MAX_RETRY, retry++ and → ISSUE (same device, eng_addr unchanged); else dev_fail[cur_dev] ← 1, retry ← 0, → GAP.
- GAP: count GAP_CYC cycles. Then → PICK if poll_en=1 and dev_mask≠0, else → IDLE.
- Timer: 24-bit, cleared on every state entry.
- Mask changes mid-transaction: take effect at the next PICK; the current transaction completes.
- poll_en dropped mid-transaction: completes, including retries.
- dev_mask=0 while in GAP: → IDLE.
- dev_addr changes mid-transaction: ignored until the next PICK.
- Reset mid-transaction: all state returns to reset values immediately; the engine is reset by the same signal.
- Simultaneous timeout and eng_done edge in the same cycle: eng_done wins.
- Index arithmetic is modulo NUM_DEV; cur_dev is zero-extended to 3 bits.

Optional Feature:
- Macro: I2C_POLL_CHANGE_IRQ_EN.
- When defined, adds:
  - irq  out  1  sticky; set the cycle after a CHECK success where eng_rdata differs from the previous rd_data[cur_dev], or when dev_fail rises.
  - irq_clr  in  1  clears irq; a set event in the same cycle as irq_clr wins.
  - Reset value of irq: 0.
- When undefined: no irq or irq_clr ports and no comparison logic; all other behaviour is identical.

Decomposition:
- Package i2c_poll_pkg:
  - State encoding: IDLE, PICK, ISSUE, WAIT, CHECK, FAIL, GAP (3-bit localparams).
  - Widths: ADDR_W=7, DATA_W=8, TMR_W=24, IDX_W=3.
- Sub-module poll_rr_pick: combinational round-robin next-index finder (inputs: mask, current index; outputs: next index, any).

Test Plan:
- NUM_DEV=2, mask=2'b11, addrs 7'h48/7'h49, engine model ACKs returning 8'hA5 then 8'h3C → rd_data = {3C,A5}, rd_upd pulses alternate 01,10, eng_addr alternates 48,49.
- Device 0 NACK always, MAX_RETRY=2 → exactly 3 eng_start assertions for addr 48, dev_fail=2'b01; a later ACK clears it to 00.
- Engine model never lowers eng_done → ISSUE times out after TMO_CYC, goes through FAIL and retries, then dev_fail sets; no hang.
- mask=4'b0100 → only device 2 is polled repeatedly; mask set to 0 during WAIT → transaction completes, state reaches IDLE, busy=0.
- Assert reset during WAIT → next cycle all outputs are 0; after release with poll_en=1, the first transaction targets device 1 (round-robin from cur_dev=0).
- With I2C_POLL_CHANGE_IRQ_EN: same byte read twice → irq stays 0; changed byte → irq=1 until irq_clr.

Source files
------------

// File: rtl/i2c_poll_pkg.sv
// Shared types and widths for the I2C poll scheduler.
// Optional feature macro: I2C_POLL_CHANGE_IRQ_EN (see i2c_poll_scheduler.sv).
package i2c_poll_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int TMR_W  = 24;
    localparam int IDX_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PICK  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CHECK = 3'd4,
        ST_FAIL  = 3'd5,
        ST_GAP   = 3'd6
    } state_t;

endpackage

// File: rtl/poll_rr_pick.sv
// Combinational round-robin finder: first enabled device after cur_i,
// wrapping modulo NUM_DEV; falls back to cur_i itself when it is the only one.
module poll_rr_pick
    import i2c_poll_pkg::*;
#(
    parameter int NUM_DEV = 4
) (
    input  logic [NUM_DEV-1:0] mask_i,
    input  logic [IDX_W-1:0]   cur_i,
    output logic [IDX_W-1:0]   nxt_o,
    output logic               any_o
);

    logic [7:0]     mask_pad;
    logic [IDX_W:0] idx;

    // Scan offsets from farthest to nearest so the nearest hit is the one that sticks.
    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch is inferred.
        mask_pad = '0;
        mask_pad[NUM_DEV-1:0] = mask_i;
        idx   = '0;
        nxt_o = cur_i;
        any_o = |mask_i;
        for (int k = NUM_DEV; k >= 1; k--) begin
            idx = {1'b0, cur_i} + (IDX_W + 1)'(k);
            if (idx >= (IDX_W + 1)'(NUM_DEV)) begin
                idx = idx - (IDX_W + 1)'(NUM_DEV);
            end
            if (mask_pad[idx[IDX_W-1:0]]) begin
                nxt_o = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/i2c_poll_scheduler.sv
// Round-robin poller sharing one I2C read engine among NUM_DEV devices,
// with per-device result capture, retry on NACK/timeout and sticky fail flags.
// Optional: define I2C_POLL_CHANGE_IRQ_EN to add a sticky change/fail irq.
module i2c_poll_scheduler
    import i2c_poll_pkg::*;
#(
    parameter int          NUM_DEV   = 4,
    parameter logic [15:0] GAP_CYC   = 16'd5000,
    parameter logic [23:0] TMO_CYC   = 24'd2000000,
    parameter int          MAX_RETRY = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      poll_en,
    input  logic [NUM_DEV-1:0]        dev_mask,
    input  logic [ADDR_W*NUM_DEV-1:0] dev_addr,
    output logic                      eng_start,
    output logic [ADDR_W-1:0]         eng_addr,
    input  logic                      eng_done,
    input  logic                      eng_ack,
    input  logic [DATA_W-1:0]         eng_rdata,
    output logic [DATA_W*NUM_DEV-1:0] rd_data,
    output logic [NUM_DEV-1:0]        rd_upd,
    output logic [NUM_DEV-1:0]        dev_fail,
    output logic [IDX_W-1:0]          cur_dev,
    output logic                      busy
`ifdef I2C_POLL_CHANGE_IRQ_EN
    ,
    input  logic                      irq_clr,
    output logic                      irq
`endif
);

    state_t                    state_q;
    logic [IDX_W-1:0]          cur_q;
    logic [IDX_W-1:0]          pick_idx;
    logic                      pick_any;
    logic [ADDR_W-1:0]         pick_addr;
    logic [ADDR_W-1:0]         eng_addr_q;
    logic                      eng_start_q;
    logic [TMR_W-1:0]          tmr_q;
    logic [2:0]                retry_q;
    logic [DATA_W*NUM_DEV-1:0] rd_q;
    logic [NUM_DEV-1:0]        upd_q;
    logic [NUM_DEV-1:0]        fail_q;
    logic                      tmo_hit;
    logic                      gap_hit;
    logic                      retry_left;

    poll_rr_pick #(.NUM_DEV(NUM_DEV)) u_pick (
        .mask_i (dev_mask),
        .cur_i  (cur_q),
        .nxt_o  (pick_idx),
        .any_o  (pick_any)
    );

    // Address of the device the round-robin search would pick now.
    always_comb begin
        pick_addr = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_addr = dev_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Timer compares are written as (tmr+1 >= limit) so a zero limit cannot underflow.
    assign tmo_hit    = ({1'b0, tmr_q} + 25'd1) >= {1'b0, TMO_CYC};
    assign gap_hit    = ({1'b0, tmr_q} + 25'd1) >= 25'(GAP_CYC);
    assign retry_left = retry_q < 3'(MAX_RETRY);

    // Main sequencer: pick, start, wait for completion, capture or retry, then idle gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            eng_addr_q  <= '0;
            eng_start_q <= 1'b0;
            tmr_q       <= '0;
            retry_q     <= '0;
            rd_q        <= '0;
            upd_q       <= '0;
            fail_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in step at the edge.
            upd_q <= '0;
            tmr_q <= tmr_q + 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    tmr_q <= '0;
                    if (poll_en && pick_any) begin
                        state_q <= ST_PICK;
                    end
                end
                ST_PICK: begin
                    tmr_q <= '0;
                    if (pick_any) begin
                        cur_q       <= pick_idx;
                        eng_addr_q  <= pick_addr;
                        eng_start_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // Engine accepting the start has priority over a same-cycle timeout.
                    if (!eng_done) begin
                        eng_start_q <= 1'b0;
                        tmr_q       <= '0;
                        state_q     <= ST_WAIT;
                    end else if (tmo_hit) begin
                        eng_start_q <= 1'b0;
                        tmr_q       <= '0;
                        state_q     <= ST_FAIL;
                    end
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        tmr_q   <= '0;
                        state_q <= ST_CHECK;
                    end else if (tmo_hit) begin
                        tmr_q   <= '0;
                        state_q <= ST_FAIL;
                    end
                end
                ST_CHECK: begin
                    tmr_q <= '0;
                    if (eng_ack) begin
                        for (int i = 0; i < NUM_DEV; i++) begin
                            if (cur_q == IDX_W'(i)) begin
                                rd_q[i*DATA_W +: DATA_W] <= eng_rdata;
                                upd_q[i]                 <= 1'b1;
                                fail_q[i]                <= 1'b0;
                            end
                        end
                        retry_q <= '0;
                        state_q <= ST_GAP;
                    end else begin
                        state_q <= ST_FAIL;
                    end
                end
                ST_FAIL: begin
                    tmr_q <= '0;
                    if (retry_left) begin
                        retry_q     <= retry_q + 3'd1;
                        eng_start_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end else begin
                        for (int i = 0; i < NUM_DEV; i++) begin
                            if (cur_q == IDX_W'(i)) begin
                                fail_q[i] <= 1'b1;
                            end
                        end
                        retry_q <= '0;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (!pick_any) begin
                        tmr_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (gap_hit) begin
                        tmr_q   <= '0;
                        state_q <= poll_en ? ST_PICK : ST_IDLE;
                    end
                end
                default: begin
                    tmr_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign eng_start = eng_start_q;
    assign eng_addr  = eng_addr_q;
    assign rd_data   = rd_q;
    assign rd_upd    = upd_q;
    assign dev_fail  = fail_q;
    assign cur_dev   = cur_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_GAP);

`ifdef I2C_POLL_CHANGE_IRQ_EN
    logic [DATA_W-1:0] cur_rd;
    logic              cur_fail;
    logic              irq_set;
    logic              irq_q;

    // Previous byte and fail flag of the device being serviced.
    always_comb begin
        cur_rd   = '0;
        cur_fail = 1'b0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (cur_q == IDX_W'(i)) begin
                cur_rd   = rd_q[i*DATA_W +: DATA_W];
                cur_fail = fail_q[i];
            end
        end
    end

    assign irq_set = ((state_q == ST_CHECK) && eng_ack && (eng_rdata != cur_rd)) ||
                     ((state_q == ST_FAIL) && !retry_left && !cur_fail);

    // Sticky interrupt; a new set event beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else if (irq_set) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_i2c_poll_scheduler.sv
// Scoreboard bench for i2c_poll_scheduler: an engine model answers start requests,
// predicts each transaction outcome and queues it; a monitor pops on rd_upd / dev_fail rise.
module tb_i2c_poll_scheduler;

    localparam int ND  = 4;
    localparam int GAP = 4;
    localparam int TMO = 50;
    localparam int MR  = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            poll_en;
    logic [ND-1:0]   dev_mask;
    logic [7*ND-1:0] dev_addr;
    logic            eng_start;
    logic [6:0]      eng_addr;
    logic            eng_done;
    logic            eng_ack;
    logic [7:0]      eng_rdata;
    logic [8*ND-1:0] rd_data;
    logic [ND-1:0]   rd_upd;
    logic [ND-1:0]   dev_fail;
    logic [2:0]      cur_dev;
    logic            busy;
`ifdef I2C_POLL_CHANGE_IRQ_EN
    logic            irq_clr;
    logic            irq;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2c_poll_scheduler #(
        .NUM_DEV   (ND),
        .GAP_CYC   (16'(GAP)),
        .TMO_CYC   (24'(TMO)),
        .MAX_RETRY (MR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .poll_en   (poll_en),
        .dev_mask  (dev_mask),
        .dev_addr  (dev_addr),
        .eng_start (eng_start),
        .eng_addr  (eng_addr),
        .eng_done  (eng_done),
        .eng_ack   (eng_ack),
        .eng_rdata (eng_rdata),
        .rd_data   (rd_data),
        .rd_upd    (rd_upd),
        .dev_fail  (dev_fail),
        .cur_dev   (cur_dev),
        .busy      (busy)
`ifdef I2C_POLL_CHANGE_IRQ_EN
        ,
        .irq_clr   (irq_clr),
        .irq       (irq)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    typedef struct {
        bit         is_fail;
        int         dev;
        logic [7:0] data;
        bit         chg;
    } ev_t;

    ev_t        exp_q[$];
    int         resp_mode[ND];   // 0 = ACK fixed byte, 1 = NACK, 2 = never responds, 3 = random
    logic [7:0] resp_data[ND];
    logic [7:0] model_rd[ND];
    bit         model_fail[ND];
    int         model_last    = 0;
    int         model_cur     = 0;
    int         attempt       = 0;
    int         starts[ND];
    int         upd_cnt       = 0;
    int         fail_cnt      = 0;
    int         last_done_cyc = -1000;
    bit         m_irq         = 1'b0;

    function automatic int addr2dev(input logic [6:0] a);
        for (int i = 0; i < ND; i++) begin
            if (dev_addr[i*7 +: 7] == a) return i;
        end
        return -1;
    endfunction

    function automatic int rr_next(input int last, input logic [ND-1:0] m);
        for (int k = 1; k <= ND; k++) begin
            if (m[(last + k) % ND]) return (last + k) % ND;
        end
        return -1;
    endfunction

    function automatic int start_sum();
        int s = 0;
        for (int i = 0; i < ND; i++) s += starts[i];
        return s;
    endfunction

    // ---------------- engine model ----------------
    int         e_st = 0;
    int         e_cnt = 0;
    logic       e_ack;
    logic [7:0] e_data;
    logic       prev_start = 1'b0;

    task automatic engine_accept();
        int         d;
        int         o;
        int         e;
        logic [7:0] data;
        ev_t        ev;
        d = addr2dev(eng_addr);
        check("eng_addr_known", d >= 0, 1);
        if (d < 0) return;
        if (attempt == 0) begin
            e = rr_next(model_last, dev_mask);
            check("rr_target", d, e);
            check("gap_min", (cyc - last_done_cyc) >= GAP, 1);
            model_last = d;
            model_cur  = d;
        end else begin
            check("retry_same_dev", d, model_cur);
        end
        starts[d]++;
        if (resp_mode[d] == 3) begin
            o    = ($urandom_range(0, 9) < 7) ? 0 : 1;
            data = 8'($urandom);
        end else begin
            o    = resp_mode[d];
            data = resp_data[d];
        end
        if (o == 0) begin
            ev.is_fail = 1'b0; ev.dev = d; ev.data = data; ev.chg = (data != model_rd[d]);
            exp_q.push_back(ev);
            model_rd[d]   = data;
            model_fail[d] = 1'b0;
            attempt       = 0;
        end else begin
            attempt++;
            if (attempt > MR) begin
                if (!model_fail[d]) begin
                    ev.is_fail = 1'b1; ev.dev = d; ev.data = 8'h00; ev.chg = 1'b1;
                    exp_q.push_back(ev);
                end
                model_fail[d] = 1'b1;
                attempt       = 0;
            end
        end
        if (o != 2) begin
            e_ack  = (o == 0);
            e_data = (o == 0) ? data : 8'($urandom);
            e_cnt  = $urandom_range(1, 3);
            e_st   = 1;
        end
    endtask

    initial begin
        eng_done  = 1'b1;
        eng_ack   = 1'b0;
        eng_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                eng_done = 1'b1; eng_ack = 1'b0; eng_rdata = 8'h00; e_st = 0;
            end else begin
                case (e_st)
                    0: if (eng_start && !prev_start) engine_accept();
                    1: begin
                        e_cnt--;
                        if (e_cnt <= 0) begin
                            eng_done = 1'b0; eng_ack = 1'b0;
                            e_cnt = $urandom_range(2, 6); e_st = 2;
                        end
                    end
                    default: begin
                        e_cnt--;
                        if (e_cnt <= 0) begin
                            eng_ack = e_ack; eng_rdata = e_data; eng_done = 1'b1;
                            last_done_cyc = cyc; e_st = 0;
                        end
                    end
                endcase
            end
            prev_start = eng_start;
        end
    end

    // ---------------- monitor ----------------
    logic [ND-1:0] prev_fail = '0;
    initial begin
        ev_t           ev;
        logic [ND-1:0] oh;
        logic [ND-1:0] rise;
        forever begin
            @(negedge clk);
            rise = dev_fail & ~prev_fail;
            if (rd_upd != '0) begin
                if (exp_q.size() == 0) check("unexpected_upd", rd_upd, 0);
                else begin
                    ev = exp_q.pop_front();
                    oh = '0; oh[ev.dev] = 1'b1;
                    check("ev_kind_upd", ev.is_fail, 0);
                    check("upd_onehot", rd_upd, oh);
                    check("rd_data", rd_data[ev.dev*8 +: 8], ev.data);
                    check("fail_clr_on_upd", dev_fail[ev.dev], 0);
                    if (ev.chg) m_irq = 1'b1;
`ifdef I2C_POLL_CHANGE_IRQ_EN
                    check("irq_on_upd", irq, m_irq);
`endif
                    upd_cnt++;
                end
            end
            if (rise != '0) begin
                if (exp_q.size() == 0) check("unexpected_fail", rise, 0);
                else begin
                    ev = exp_q.pop_front();
                    oh = '0; oh[ev.dev] = 1'b1;
                    check("ev_kind_fail", ev.is_fail, 1);
                    check("fail_rise", rise, oh);
                    m_irq = 1'b1;
`ifdef I2C_POLL_CHANGE_IRQ_EN
                    check("irq_on_fail", irq, 1);
`endif
                    fail_cnt++;
                end
            end
            prev_fail = dev_fail;
        end
    end

    // ---------------- sequencing helpers ----------------
    task automatic go_idle();
        int n = 0;
        poll_en = 1'b0;
        while (busy && n < 3000) begin @(negedge clk); n++; end
        check("idle_reached", busy, 0);
        repeat (GAP + 4) @(negedge clk);
        check("idle_no_start", eng_start, 0);
    endtask

    task automatic wait_events(input int n, input string name);
        int target = upd_cnt + fail_cnt + n;
        int k = 0;
        while ((upd_cnt + fail_cnt) < target && k < 20000) begin @(negedge clk); k++; end
        check(name, (upd_cnt + fail_cnt) >= target, 1);
    endtask

    task automatic wait_fail(input string name);
        int target = fail_cnt + 1;
        int k = 0;
        while (fail_cnt < target && k < 20000) begin @(negedge clk); k++; end
        check(name, fail_cnt >= target, 1);
    endtask

    task automatic wait_in_wait(input string name);
        int k = 0;
        while (eng_done && k < 3000) begin @(negedge clk); k++; end
        check(name, eng_done, 0);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_eng_start"}, eng_start, 0);
        check({tag, "_eng_addr"},  eng_addr,  0);
        check({tag, "_rd_data"},   rd_data,   0);
        check({tag, "_rd_upd"},    rd_upd,    0);
        check({tag, "_dev_fail"},  dev_fail,  0);
        check({tag, "_cur_dev"},   cur_dev,   0);
        check({tag, "_busy"},      busy,      0);
    endtask

`ifdef I2C_POLL_CHANGE_IRQ_EN
    task automatic pulse_irq_clr();
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        m_irq   = 1'b0;
        @(negedge clk);
        check("irq_cleared", irq, 0);
    endtask
`endif

    // ---------------- main stimulus ----------------
    initial begin
        int t0;
        int elapsed;
        int s0;
        int k;
        reset    = 1'b1;
        poll_en  = 1'b0;
        dev_mask = '0;
        dev_addr = {7'h4B, 7'h4A, 7'h49, 7'h48};
`ifdef I2C_POLL_CHANGE_IRQ_EN
        irq_clr  = 1'b0;
`endif
        for (int i = 0; i < ND; i++) begin
            resp_mode[i] = 0; resp_data[i] = 8'h00; model_rd[i] = 8'h00;
            model_fail[i] = 1'b0; starts[i] = 0;
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Two devices alternating with fixed bytes.
        resp_data[0] = 8'hA5; resp_data[1] = 8'h3C;
        dev_mask = 4'b0011; poll_en = 1'b1;
        wait_events(4, "pair_events");
        go_idle();
        check("pair_rd_data", rd_data[15:0], 16'h3CA5);

        // Device 0 always NACKs: three attempts, then sticky fail.
        starts = '{default: 0};
        resp_mode[0] = 1;
        poll_en = 1'b1;
        wait_fail("nack_fail_seen");
        go_idle();
        check("nack_starts", starts[0], 3);
        check("nack_dev_fail", dev_fail, 4'b0001);
        resp_mode[0] = 0; resp_data[0] = 8'h5A;
        dev_mask = 4'b0001; poll_en = 1'b1;
        wait_events(1, "recover_event");
        go_idle();
        check("recover_dev_fail", dev_fail, 4'b0000);
        check("recover_rd_data", rd_data[7:0], 8'h5A);

        // Engine never responds: each attempt must time out, then fail.
        starts = '{default: 0};
        resp_mode[0] = 2;
        t0 = cyc; poll_en = 1'b1;
        wait_fail("tmo_fail_seen");
        elapsed = cyc - t0;
        go_idle();
        check("tmo_starts", starts[0], 3);
        check("tmo_min_time", elapsed >= 3 * TMO, 1);
        check("tmo_max_time", elapsed <= 3 * (TMO + 10) + GAP + 20, 1);
        check("tmo_dev_fail", dev_fail, 4'b0001);
        resp_mode[0] = 0;

        // Only device 2 enabled; drop the mask mid-transaction.
        starts = '{default: 0};
        resp_mode[2] = 3;
        dev_mask = 4'b0100; poll_en = 1'b1;
        wait_events(3, "single_dev_events");
        wait_in_wait("single_dev_wait");
        dev_mask = 4'b0000;
        k = 0;
        while (busy && k < 3000) begin @(negedge clk); k++; end
        repeat (GAP + 4) @(negedge clk);
        check("mask0_busy", busy, 0);
        check("mask0_start", eng_start, 0);
        check("mask0_drained", exp_q.size(), 0);
        s0 = start_sum();
        repeat (20) @(negedge clk);
        check("mask0_no_more", start_sum(), s0);
        check("single_dev_only", starts[0] + starts[1] + starts[3], 0);
        poll_en = 1'b0;

        // Randomised masks and outcomes.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < ND; i++) resp_mode[i] = 3;
            dev_mask = 4'($urandom_range(1, 15));
            poll_en = 1'b1;
            wait_events(8, "random_events");
            go_idle();
        end

        // Reset in the middle of a transaction.
        for (int i = 0; i < ND; i++) begin resp_mode[i] = 0; resp_data[i] = 8'($urandom); end
        dev_mask = 4'b1111; poll_en = 1'b1;
        wait_in_wait("pre_reset_wait");
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        exp_q.delete();
        model_last = 0; attempt = 0; m_irq = 1'b0;
        for (int i = 0; i < ND; i++) begin
            model_rd[i] = 8'h00; model_fail[i] = 1'b0; starts[i] = 0;
        end
        reset = 1'b0;
        k = 0;
        while (start_sum() == 0 && k < 1000) begin @(negedge clk); k++; end
        check("first_after_reset", starts[1], 1);
        wait_events(2, "post_reset_events");
        go_idle();

`ifdef I2C_POLL_CHANGE_IRQ_EN
        // Same byte twice keeps irq low; a changed byte raises it until cleared.
        dev_mask = 4'b0001; resp_mode[0] = 0; resp_data[0] = 8'h77;
        poll_en = 1'b1;
        wait_events(1, "irq_prime");
        go_idle();
        pulse_irq_clr();
        poll_en = 1'b1;
        wait_events(2, "irq_same_events");
        go_idle();
        check("irq_same_byte", irq, 0);
        resp_data[0] = 8'h88;
        poll_en = 1'b1;
        wait_events(1, "irq_change_event");
        go_idle();
        check("irq_changed_byte", irq, 1);
        pulse_irq_clr();
`endif

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
